// File: rtl/serial_sub_nbit_pkg.sv
// rtl/serial_sub_nbit_pkg.sv - shared FSM state encoding and width limits for serial_sub_nbit
package serial_sub_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_ok(int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_sub_1_bit.sv
// rtl/full_sub_1_bit.sv - 1-bit full subtractor cell: d = a - b - bin
module full_sub_1_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub_nbit.sv
// rtl/serial_sub_nbit.sv - bit-serial WIDTH-bit subtractor, LSB first, start/done handshake
// Optional zero/ovf flag outputs under macro SERIAL_SUB_FLAGS_EN.
module serial_sub_nbit
  import serial_sub_nbit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_sub_nbit: WIDTH out of range");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_x_sr;
  logic [WIDTH-1:0] r_y_sr;
  logic [WIDTH-1:0] w_x_next;
  logic [WIDTH-1:0] w_y_next;
  logic             r_brw;
  logic             w_d;
  logic             w_brw_next;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] r_dif;
  logic             r_bout;

  full_sub_1_bit u_cell (
    .i_a    (r_x_sr[0]),
    .i_b    (r_y_sr[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_brw_next)
  );

  // Difference bits fill the minuend register from the top as its bits are consumed.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_x_next = w_d;
      assign w_y_next = 1'b0;
    end else begin : g_wn
      assign w_x_next = {w_d, r_x_sr[WIDTH-1:1]};
      assign w_y_next = {1'b0, r_y_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_sr <= '0;
      r_y_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_dif  <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x_sr <= x;
            r_y_sr <= y;
            r_brw  <= bin;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          r_x_sr <= w_x_next;
          r_y_sr <= w_y_next;
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_dif  <= w_x_next;
            r_bout <= w_brw_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic r_x_msb;
  logic r_y_msb;
  logic r_zero;
  logic r_ovf;

  // Operand sign bits are shifted away during RUN, so keep a copy for overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_msb <= 1'b0;
      r_y_msb <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_x_msb <= x[WIDTH-1];
      r_y_msb <= y[WIDTH-1];
    end else if (r_state == ST_RUN && w_last) begin
      r_zero <= (w_x_next == '0);
      r_ovf  <= (r_x_msb != r_y_msb) && (w_x_next[WIDTH-1] != r_x_msb);
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign dif  = r_dif;
  assign bout = r_bout;

endmodule
